// File: rtl/input_conditioner.sv
// Two-channel debouncer: 2-flop synchronizer, stability counter and registered output per channel.
// Optional build macro INPUT_COND_ONESHOT_EN turns a/b into one-cycle rising-edge pulses.
module input_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Bit 0 is channel A, bit 1 is channel B throughout.
  logic [1:0]            s1;
  logic [1:0]            s2;
  logic [1:0]            lvl;
  logic [1:0]            lvl_nxt;
  logic [1:0]            out;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0][CNT_W-1:0] cnt_nxt;

  always_comb begin
    lvl_nxt = lvl;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (s2[i] != lvl[i]) begin
        if (cnt[i] == CNT_LAST) begin
          lvl_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
      lvl <= '0;
      out <= '0;
      evt <= 1'b0;
    end else begin
      s1  <= {b_raw, a_raw};
      s2  <= s1;
      cnt <= cnt_nxt;
      lvl <= lvl_nxt;
      evt <= |(lvl_nxt ^ lvl);
`ifdef INPUT_COND_ONESHOT_EN
      out <= lvl_nxt & ~lvl;
`else
      out <= lvl_nxt;
`endif
    end
  end

  assign a = out[0];
  assign b = out[1];

endmodule
